// File: rtl/divider_pkg.sv
// Shared types and helpers for the execute-stage divider.
//   u64 / u65     : operand-width and operand-width+1 vectors
//   div_state_t   : divider FSM states
//   DIV_DELAY     : restoring iterations per normal-path operation
//   abs_w()       : magnitude of a value that may be two's-complement
package divider_pkg;

  localparam int DIV_W     = 64;
  localparam int DIV_DELAY = 64;

  typedef logic [DIV_W-1:0] u64;
  typedef logic [DIV_W:0]   u65;

  typedef enum logic [1:0] {IDLE, RUN, FIN} div_state_t;

  // Magnitude when the value is signed and negative, raw bits otherwise.
  // The most negative value maps to itself, which reads correctly as unsigned.
  function automatic u64 abs_w(input u64 x, input logic sgn);
    return (sgn && x[DIV_W-1]) ? u64'(-x) : x;
  endfunction

endpackage

// File: rtl/divider.sv
// Multi-cycle restoring radix-2 integer divider (div/divu/rem/remu).
// One quotient bit per RUN cycle; special cases (divide by zero, signed
// overflow) skip RUN and finish the cycle after acceptance.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   valid      request, sampled only in IDLE
//   is_signed  1 = two's-complement operation, sampled with valid
//   a, b       dividend / divisor, sampled with valid
//   done       one-cycle pulse, q/r valid in that cycle
//   q, r       registered quotient / remainder, held until next result
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;   // partial remainder, always < divisor so WIDTH bits suffice
  logic [WIDTH-1:0] dvd;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;
  logic             q_neg, r_neg;

  logic accept, step, finish;
  logic div_zero, ovf, special;

  assign div_zero = (b == '0);
  assign ovf      = is_signed && (a == MIN_NEG) && (b == '1);
  assign special  = div_zero || ovf;

  // Restoring step on the shifted {rem,dvd} pair. Since rem < dvs, the
  // shifted remainder is < 2*dvs, so the difference fits in WIDTH+1 bits
  // and its top bit is a valid borrow flag.
  u65   rem_sh;
  u65   diff;
  logic ge;

  assign rem_sh = {rem, dvd[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign ge     = ~diff[WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (valid) state_nx = special ? FIN : RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    accept = (state == IDLE) && valid;
    step   = (state == RUN);
    finish = (state == FIN);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        cnt <= CNT_W'(DIV_DELAY);
        dvs <= abs_w(b, is_signed);
        // Special results are preloaded with signs cleared so FIN passes them through.
        if (div_zero) begin
          dvd   <= '1;
          rem   <= a;
          q_neg <= 1'b0;
          r_neg <= 1'b0;
        end else if (ovf) begin
          dvd   <= a;
          rem   <= '0;
          q_neg <= 1'b0;
          r_neg <= 1'b0;
        end else begin
          dvd   <= abs_w(a, is_signed);
          rem   <= '0;
          q_neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          r_neg <= is_signed & a[WIDTH-1];
        end
      end else if (step) begin
        cnt <= cnt - CNT_W'(1);
        rem <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dvd <= {dvd[WIDTH-2:0], ge};
      end
      if (finish) begin
        q <= q_neg ? -dvd : dvd;
        r <= r_neg ? -rem : rem;
      end
    end
  end

endmodule
